instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, giving the instruction queue entry count (power of two, >=2).
REQ-002 SHALL provide parameter RESET_PC, default 64'd0, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port redirect, input, 1, branch-taken redirect from the memory stage.
REQ-006 SHALL have port redirect_pc, input, 64, target address accompanying redirect.
REQ-007 SHALL have port stall, input, 1, decode-stage hold; head instruction not consumed.
REQ-008 SHALL have port imem_req, output, 1, fetch request valid.
REQ-009 SHALL have port imem_addr, output, 64, fetch byte address.
REQ-010 SHALL have port imem_ready, input, 1, memory accepts the request this cycle.
REQ-011 SHALL have port imem_rvalid, input, 1, in-order fetch response valid.
REQ-012 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-013 SHALL have port inst_valid, output, 1, queue head valid toward the IF/DE register.
REQ-014 SHALL have port inst, output, 32, queue head instruction.
REQ-015 SHALL have port inst_pc, output, 64, byte address of the queue head instruction.

Function
REQ-016 SHALL hold fetch_pc, outstanding count (0..DEPTH), drop count (0..DEPTH), resp_pc, and a DEPTH-entry FIFO of {inst, pc}.
REQ-017 SHALL drive imem_addr = fetch_pc at all times.
REQ-018 SHALL assert imem_req only when redirect is 0 and (FIFO occupancy + outstanding) < DEPTH.
REQ-019 SHALL count a request as accepted when imem_req and imem_ready are both 1: fetch_pc += 4 (mod 2^64), outstanding += 1.
REQ-020 SHALL decrement outstanding on each cycle with imem_rvalid=1 and outstanding>0; an accept and a response in the same cycle leave outstanding unchanged.
REQ-021 SHALL ignore imem_rvalid when outstanding=0 (no push, no counter change).
REQ-022 SHALL discard a response while drop count>0, decrementing drop count; otherwise push {imem_rdata, resp_pc} and advance resp_pc += 4.
REQ-023 SHALL drive inst_valid = FIFO non-empty, with inst/inst_pc from the head entry; head data is valid the cycle after the push (no bypass).
REQ-024 SHALL pop the head when inst_valid=1 and stall=0 and redirect=0.
REQ-025 SHALL allow push and pop in the same cycle, including at full; occupancy then stays unchanged.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH, keeping FIFO order through the wrap.
REQ-027 SHALL never push when the FIFO is full. The credit rule in REQ-018 guarantees this; overflow is a design error flagged by an assertion.
REQ-028 On redirect=1 (priority over stall and pop) SHALL: empty the FIFO, set fetch_pc and resp_pc to redirect_pc, and set drop count to the in-flight count (outstanding after this cycle's response, if any) and clear outstanding.
REQ-029 SHALL treat a response arriving in the redirect cycle as discarded.
REQ-030 SHALL keep inst/inst_pc unchanged under stall while inst_valid=1.

Reset
REQ-031 While reset=0, SHALL asynchronously force: fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0, drop count=0, inst_valid=0, imem_req=0, inst=32'd0, inst_pc=RESET_PC.
REQ-032 SHALL discard all in-flight state on reset mid-operation, and SHALL issue its first request at RESET_PC in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, imem_ready=1, 1-cycle memory returning addr-tagged words, stall=0 -> inst_pc sequence 0,4,8,12... in consecutive cycles, with inst matching.
REQ-034 stall=1 held 10 cycles -> exactly DEPTH=4 entries buffered, imem_req=0, head stays at inst_pc=0x0; on stall release, 0x0..0xC drain in order with no gap.
REQ-035 Redirect to 0x100 with 2 requests in flight -> those 2 responses are discarded; the next inst_valid shows inst_pc=0x100, and no stale word appears.
REQ-036 Redirect asserted together with stall=1 and a full FIFO -> FIFO flushed next cycle and the fetch resumes at redirect_pc.
REQ-037 Memory latency 3 cycles with random imem_ready -> in-order delivery, outstanding never >4, and no overflow assertion across 200 instructions with pointer wrap.
REQ-038 reset pulsed low mid-stream with 3 entries queued -> inst_valid=0 immediately (asynchronous), then refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch into a small {inst, pc} queue,
// with branch redirect that flushes the queue and drops stale in-flight responses.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned UW = CW + 2;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    logic [31:0]   mem_inst [DEPTH];
    logic [63:0]   mem_pc   [DEPTH];

    logic [UW-1:0] used;
    logic          accept;
    logic          rsp_live;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          push;
    logic          pop;

    // Dropped requests still hold a credit until their response returns, so the
    // queue can never be oversubscribed and drop count stays within 0..DEPTH.
    assign used     = UW'(count_q) + UW'(outst_q) + UW'(drop_q);
    assign imem_req = reset && !redirect && (used < UW'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign accept   = imem_req && imem_ready;

    // Memory is in order, so the oldest drop_q responses always belong to stale requests.
    assign rsp_live = imem_rvalid && ((outst_q != '0) || (drop_q != '0));
    assign rsp_drop = rsp_live && (drop_q != '0);
    assign rsp_keep = rsp_live && (drop_q == '0);
    assign push     = rsp_keep && !redirect;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && !stall && !redirect;
    assign inst       = inst_valid ? mem_inst[rptr_q] : 32'd0;
    assign inst_pc    = inst_valid ? mem_pc[rptr_q] : RESET_PC;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end

        case ({accept, rsp_keep})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase

        if (rsp_drop) begin
            drop_d = drop_q - CNT_ONE;
        end

        if (push) begin
            resp_pc_d = resp_pc_q + 64'd4;
            wptr_d    = wptr_q + PTR_ONE;
        end

        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = drop_q + outst_q - (rsp_live ? CNT_ONE : '0);
            outst_d    = '0;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // NOTE: queue storage is not reset; outputs are masked by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wptr_q] <= imem_rdata;
            mem_pc[wptr_q]   <= resp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == CNT_FULL)));

endmodule
